// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin front end that shares a bank of JK flip-flops
// among several requesters. Each accepted command produces a one-cycle J/K
// pulse on its target flip-flop. One cycle later the flip-flop's Q is
// returned to the requester that sent the command.
//
// Handshake: a requester raises req_valid[r] and holds its op and idx steady
// until req_ready[r] is seen high. The transfer happens on the rising edge
// where both are high. req_ready is combinational and is only high in IDLE,
// for the single round-robin winner. A request that is dropped before it is
// granted is simply not served.
module jk_bank_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [IDX_W*NUM_REQ-1:0] req_idx,
    output logic [WIDTH-1:0]         jk_j,
    output logic [WIDTH-1:0]         jk_k,
    input  logic [WIDTH-1:0]         q_in,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_q,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_id;
    logic [IDX_W-1:0]  r_idx;
    logic              r_err;
    logic [WIDTH-1:0]  r_jk_j;
    logic [WIDTH-1:0]  r_jk_k;

    logic              w_found;
    logic [ID_W-1:0]   w_winner;
    logic [1:0]        w_op;
    logic [IDX_W-1:0]  w_idx;
    logic [WIDTH-1:0]  w_onehot;
    logic              w_idx_err;
    logic              w_grant;
    logic              w_q_sel;

    // Round-robin search: the first valid requester after the last winner, wrapping around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!w_found && req_valid[r] && (r == (int'(r_rr_ptr) + i) % NUM_REQ)) begin
                    w_found  = 1'b1;
                    w_winner = ID_W'(r);
                end
            end
        end
    end

    // Select the winner's command fields, decode the target one-hot, and drive ready.
    always_comb begin
        w_op      = '0;
        w_idx     = '0;
        w_onehot  = '0;
        req_ready = '0;
        w_grant   = (r_state == S_IDLE) && w_found;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (int'(w_winner) == r) begin
                w_op  = req_op[2*r +: 2];
                w_idx = req_idx[IDX_W*r +: IDX_W];
            end
            req_ready[r] = w_grant && (int'(w_winner) == r);
        end
        for (int b = 0; b < WIDTH; b++) begin
            w_onehot[b] = (int'(w_idx) == b);
        end
        w_idx_err = (int'(w_idx) >= WIDTH);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: IDLE waits for a grant, then one ISSUE cycle and one CAPTURE cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_found) w_next_state = S_ISSUE;
            S_ISSUE:   w_next_state = S_CAPTURE;
            S_CAPTURE: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Latch the granted command. J/K is registered, so the pulse lands exactly in ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= ID_W'(NUM_REQ - 1);
            r_id     <= '0;
            r_idx    <= '0;
            r_err    <= 1'b0;
            r_jk_j   <= '0;
            r_jk_k   <= '0;
        end else begin
            r_jk_j <= '0;
            r_jk_k <= '0;
            if (w_grant) begin
                r_rr_ptr <= w_winner;
                r_id     <= w_winner;
                r_idx    <= w_idx;
                r_err    <= w_idx_err;
                // An out-of-range index has an all-zero one-hot, so no flip-flop is disturbed.
                r_jk_j   <= w_op[1] ? w_onehot : '0;
                r_jk_k   <= w_op[0] ? w_onehot : '0;
            end
        end
    end

    // Pick the target's Q straight from the bank; an out-of-range index reads as 0.
    always_comb begin
        w_q_sel = 1'b0;
        for (int b = 0; b < WIDTH; b++) begin
            if (int'(r_idx) == b) w_q_sel = q_in[b];
        end
    end

    // Response outputs are only non-zero in CAPTURE, after the bank has taken its update.
    always_comb begin
        rsp_valid = (r_state == S_CAPTURE);
        rsp_id    = rsp_valid ? r_id : '0;
        rsp_err   = rsp_valid && r_err;
        rsp_q     = rsp_valid && !r_err && w_q_sel;
        busy      = (r_state != S_IDLE);
        jk_j      = r_jk_j;
        jk_k      = r_jk_k;
        dbg_state = r_state;
    end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter. It contains a behavioural JK bank driven by the
// DUT, directed table vectors, multi-cycle corner sequences, and a randomized
// phase that is checked against a transaction-level model.
module tb_jk_bank_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  req_op;
    logic [15:0] req_idx;
    logic [7:0]  jk_j;
    logic [7:0]  jk_k;
    logic [7:0]  q_in;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic        rsp_q;
    logic        rsp_err;
    logic        busy;
    logic [1:0]  dbg_state;
    logic [7:0]  bank_q;

    int n_checks = 0;
    int n_err    = 0;

    jk_bank_arbiter #(.WIDTH(8), .NUM_REQ(4), .IDX_W(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_idx(req_idx),
        .jk_j(jk_j), .jk_k(jk_k), .q_in(q_in),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_err(rsp_err),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / bank ----------------
    always #5 clk = ~clk;

    // JK bank: Q is a plain register output sharing the same clock and reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_q <= '0;
        end else begin
            for (int b = 0; b < 8; b++) begin
                case ({jk_j[b], jk_k[b]})
                    2'b01:   bank_q[b] <= 1'b0;
                    2'b10:   bank_q[b] <= 1'b1;
                    2'b11:   bank_q[b] <= ~bank_q[b];
                    default: bank_q[b] <= bank_q[b];
                endcase
            end
        end
    end
    assign q_in = bank_q;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Single-requester transaction; it starts and ends at posedge+1 of an IDLE cycle.
    task automatic do_op(input int rid, input logic [1:0] op, input logic [3:0] idx,
                         input logic [7:0] ej, input logic [7:0] ek,
                         input logic eq, input logic eerr, input string name);
        req_valid = 4'(1 << rid);
        req_op[2*rid +: 2]  = op;
        req_idx[4*rid +: 4] = idx;
        #1;
        chk({name, "_grant"}, {req_ready, busy}, {4'(1 << rid), 1'b0});
        tick();
        req_valid = '0;
        #1;
        chk({name, "_jk_j"}, jk_j, ej);
        chk({name, "_jk_k"}, jk_k, ek);
        chk({name, "_issue"}, {busy, rsp_valid, req_ready}, {1'b1, 1'b0, 4'b0});
        tick();
        #1;
        chk({name, "_rsp"}, {rsp_valid, rsp_id, rsp_q, rsp_err, busy},
            {1'b1, 2'(rid), eq, eerr, 1'b1});
        tick();
    endtask

    // Records from multi-requester runs.
    int         g_ids[8];
    int         g_cyc[8];
    int         r_ids[8];
    logic       r_qs[8];
    logic [7:0] iss_j[8];
    logic [7:0] iss_k[8];
    int         ng;
    int         nr;
    int         maxpop;

    // Hold the requesters in mask valid until n grants are seen, then collect n responses.
    task automatic run_multi(input logic [3:0] mask, input int n);
        logic drop;
        logic iss_pending;
        int   budget;
        drop = 1'b0;
        iss_pending = 1'b0;
        ng = 0;
        nr = 0;
        maxpop = 0;
        budget = n * 3 + 8;
        req_valid = mask;
        for (int c = 0; c < budget && nr < n; c++) begin
            #1;
            if ($countones(req_ready) > maxpop) maxpop = $countones(req_ready);
            if (iss_pending && ng > 0) begin
                iss_j[ng-1] = jk_j;
                iss_k[ng-1] = jk_k;
                iss_pending = 1'b0;
            end
            if (req_ready != 4'b0 && ng < 8) begin
                for (int r = 0; r < 4; r++) if (req_ready[r]) g_ids[ng] = r;
                g_cyc[ng] = c;
                ng++;
                iss_pending = 1'b1;
                if (ng == n) drop = 1'b1;
            end
            if (rsp_valid && nr < 8) begin
                r_ids[nr] = int'(rsp_id);
                r_qs[nr]  = rsp_q;
                nr++;
            end
            tick();
            if (drop) req_valid = '0;
        end
        req_valid = '0;
        chk("multi_grant_count", ng, n);
        chk("multi_rsp_count", nr, n);
        chk("multi_one_hot_ready", (maxpop <= 1), 1);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int         rid;
        logic [1:0] op;
        logic [3:0] idx;
        logic [7:0] ej;
        logic [7:0] ek;
        logic       eq;
        logic       eerr;
    } vec_t;

    vec_t tbl[10];

    // ---------------- random-phase model state ----------------
    logic        m_v[4];
    logic [1:0]  m_op[4];
    logic [3:0]  m_idx[4];
    logic [15:0] m_bank;
    logic [19:0] exp_q[$];

    initial begin
        int         m_rr;
        int         m_free;
        int         jk_due;
        int         gw;
        logic [7:0] m_ej;
        logic [7:0] m_ek;
        logic [3:0] exp_ready;
        logic [4:0] exp_rsp;
        logic       nq;
        logic       nerr;

        reset = 1'b1;
        req_valid = '0;
        req_op = '0;
        req_idx = '0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("reset_ready_jk", {req_ready, jk_j, jk_k}, 20'h0);
        chk("reset_rsp", {rsp_valid, rsp_id, rsp_q, rsp_err}, 5'h0);
        chk("reset_busy_state", {busy, dbg_state}, 3'b000);
        tick();

        // Table: expected values follow from JK rules applied to a zeroed bank in order.
        tbl[0] = '{0, 2'b10, 4'd3, 8'h08, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{2, 2'b11, 4'd3, 8'h08, 8'h08, 1'b0, 1'b0};
        tbl[2] = '{2, 2'b11, 4'd3, 8'h08, 8'h08, 1'b1, 1'b0};
        tbl[3] = '{1, 2'b10, 4'd5, 8'h20, 8'h00, 1'b1, 1'b0};
        tbl[4] = '{1, 2'b01, 4'd5, 8'h00, 8'h20, 1'b0, 1'b0};
        tbl[5] = '{3, 2'b00, 4'd3, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[6] = '{0, 2'b11, 4'd9, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[7] = '{3, 2'b00, 4'd3, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[8] = '{2, 2'b10, 4'd7, 8'h80, 8'h00, 1'b1, 1'b0};
        tbl[9] = '{0, 2'b00, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].rid, tbl[i].op, tbl[i].idx, tbl[i].ej, tbl[i].ek,
                  tbl[i].eq, tbl[i].eerr, $sformatf("vec%0d", i));
        end

        // Back-to-back toggles of idx 3 (currently 1) from requester 2.
        req_op[5:4]   = 2'b11;
        req_idx[11:8] = 4'd3;
        run_multi(4'b0100, 2);
        chk("b2b_spacing", g_cyc[1] - g_cyc[0], 3);
        chk("b2b_q", {r_qs[0], r_qs[1]}, 2'b01);

        // Reset lands during ISSUE of a set to idx 1.
        req_valid = 4'b0001;
        req_op[1:0] = 2'b10;
        req_idx[3:0] = 4'd1;
        #1;
        chk("rst_issue_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        reset = 1'b1;
        #1;
        chk("rst_issue_jk", {jk_j, jk_k}, 16'h0200);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_after_jk", {jk_j, jk_k}, 16'h0);
        chk("rst_after_rsp", {rsp_valid, busy, dbg_state}, 4'b0);
        tick();
        #1;
        chk("rst_after_rsp2", {rsp_valid, busy}, 2'b0);
        tick();

        // All four reading continuously: the order restarts at requester 0.
        req_op = '0;
        req_idx = '0;
        run_multi(4'b1111, 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rr_grant%0d", i), g_ids[i], i % 4);
            chk($sformatf("rr_rsp_id%0d", i), r_ids[i], i % 4);
        end
        chk("rr_spacing", g_cyc[5] - g_cyc[0], 15);

        // Requesters 1 and 3 both reset idx 5, which is first preset to 1.
        do_op(1, 2'b10, 4'd5, 8'h20, 8'h00, 1'b1, 1'b0, "preset5");
        do_op(0, 2'b00, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, "move_ptr");
        req_op[3:2]   = 2'b01;
        req_idx[7:4]  = 4'd5;
        req_op[7:6]   = 2'b01;
        req_idx[15:12] = 4'd5;
        run_multi(4'b1010, 2);
        chk("same_idx_order", {2'(g_ids[0]), 2'(g_ids[1])}, {2'd1, 2'd3});
        chk("same_idx_q", {r_qs[0], r_qs[1]}, 2'b00);
        chk("same_idx_jk0", {iss_j[0], iss_k[0]}, 16'h0020);
        chk("same_idx_jk1", {iss_j[1], iss_k[1]}, 16'h0020);

        // Randomized phase from a clean reset: spec-level model of grants, bank and responses.
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_rr = 3;
        m_free = 0;
        jk_due = -1;
        m_ej = '0;
        m_ek = '0;
        m_bank = '0;
        for (int r = 0; r < 4; r++) begin
            m_v[r] = 1'b0;
            m_op[r] = '0;
            m_idx[r] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!m_v[r] && $urandom_range(0, 2) == 0) begin
                    m_v[r]   = 1'b1;
                    m_op[r]  = 2'($urandom_range(0, 3));
                    m_idx[r] = 4'($urandom_range(0, 9));
                end
                req_valid[r]        = m_v[r];
                req_op[2*r +: 2]    = m_op[r];
                req_idx[4*r +: 4]   = m_idx[r];
            end
            #1;
            chk("rand_jk", {jk_j, jk_k}, (jk_due == c) ? {m_ej, m_ek} : 16'h0);
            exp_rsp = 5'b0;
            if (exp_q.size() > 0 && exp_q[0][19:4] == 16'(c)) begin
                exp_rsp = {1'b1, exp_q[0][3:0]};
                void'(exp_q.pop_front());
            end
            chk("rand_rsp", {rsp_valid, rsp_id, rsp_q, rsp_err}, exp_rsp);
            exp_ready = '0;
            gw = -1;
            if (c >= m_free) begin
                for (int k = 1; k <= 4; k++) begin
                    if (gw < 0 && m_v[(m_rr + k) % 4]) gw = (m_rr + k) % 4;
                end
            end
            if (gw >= 0) begin
                exp_ready[gw] = 1'b1;
                if (m_idx[gw] < 4'd8) begin
                    case (m_op[gw])
                        2'b00:   nq = m_bank[m_idx[gw]];
                        2'b01:   nq = 1'b0;
                        2'b10:   nq = 1'b1;
                        default: nq = ~m_bank[m_idx[gw]];
                    endcase
                    m_bank[m_idx[gw]] = nq;
                    nerr = 1'b0;
                    m_ej = m_op[gw][1] ? 8'(1 << m_idx[gw]) : 8'h0;
                    m_ek = m_op[gw][0] ? 8'(1 << m_idx[gw]) : 8'h0;
                end else begin
                    nq = 1'b0;
                    nerr = 1'b1;
                    m_ej = 8'h0;
                    m_ek = 8'h0;
                end
                jk_due = c + 1;
                exp_q.push_back({16'(c + 2), 2'(gw), nq, nerr});
                m_rr = gw;
                m_free = c + 3;
            end
            chk("rand_ready", req_ready, exp_ready);
            tick();
            if (gw >= 0) m_v[gw] = 1'b0;
        end
        req_valid = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Round-robin controller that shares a bank of WIDTH JK flip-flops (JKflipflop instances) among NUM_REQ requesters.
- Each requester issues one command per handshake (read/hold, reset, set, toggle) targeting one flip-flop index.
- The block drives a one-cycle J/K pulse to the selected flip-flop, samples its Q after the update, and returns the result to the winning requester.
- It sits between the requester logic and the JK bank; the bank's clk/reset are shared with this block.

Parameters:
- WIDTH, 8, number of JK flip-flops in the controlled bank.
- NUM_REQ, 4, number of requesters.
- IDX_W, $clog2(WIDTH) (min 1), width of the flip-flop index field.
- ID_W, $clog2(NUM_REQ) (min 1), width of the requester id.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester command valid.
- req_ready  output  NUM_REQ  per-requester grant/accept; at most one bit high.
- req_op  input  2*NUM_REQ  per-requester op, slice [2r+1:2r]: 00 read (J=0,K=0), 01 reset (J=0,K=1), 10 set (J=1,K=0), 11 toggle (J=1,K=1).
- req_idx  input  IDX_W*NUM_REQ  per-requester target flip-flop index.
- jk_j  output  WIDTH  J inputs to the bank.
- jk_k  output  WIDTH  K inputs to the bank.
- q_in  input  WIDTH  Q outputs from the bank.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_id  output  ID_W  requester that owns the response.
- rsp_q  output  1  post-operation Q of the target flip-flop.
- rsp_err  output  1  target index >= WIDTH; no J/K issued.
- busy  output  1  high in ISSUE and CAPTURE.

Behaviour:
- Clock and reset:
  - Single clock domain, synchronous active-high reset.
  - On reset: state=IDLE, req_ready=0, jk_j=0, jk_k=0, rsp_valid=0, rsp_id=0, rsp_q=0, rsp_err=0, busy=0, rr_ptr=NUM_REQ-1 (requester 0 has top priority first).
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE:
  - Winner is the first r with req_valid[r]=1, searching from (rr_ptr+1) mod NUM_REQ upward with wrap.
  - req_ready[winner] is combinational from state==IDLE and the winner, so the handshake completes in that same cycle.
  - On the handshake, latch op, idx and id; set rr_ptr=winner; go to ISSUE.
  - No valid request: stay in IDLE with outputs idle.
- ISSUE (exactly 1 cycle):
  - jk_j/jk_k are registered and nonzero only in this cycle: bit idx carries the op's J/K, all other bits are 0.
  - The bank updates on the clock edge that ends ISSUE.
  - If idx >= WIDTH, jk_j/jk_k stay all-zero and the error flag is latched.
  - Next state: CAPTURE.
- CAPTURE (exactly 1 cycle):
  - rsp_valid=1, rsp_id=latched id, rsp_q=q_in[idx] (0 on error), rsp_err=error flag.
  - Next state: IDLE.
- Latency and throughput:
  - Handshake in cycle t, J/K in t+1, response in t+2, next grant earliest t+3.
  - Maximum throughput: one op per 3 cycles.
- req_ready is 0 in ISSUE and CAPTURE. Requesters hold valid/op/idx stable until ready; a request dropped before ready is simply not served.
- Fairness: a continuously requesting requester is granted at most once per NUM_REQ grants when all requesters are active.
- Only one flip-flop receives a nonzero J/K per cycle. Two requesters targeting the same idx are serialized in grant order; each sees its own post-op Q.
- Reset asserted in ISSUE or CAPTURE:
  - The in-flight op is abandoned and no rsp_valid is produced.
  - jk_j/jk_k are 0 from the next cycle.
  - If reset lands on the ISSUE edge, the bank's own synchronous reset wins.
- rsp_q reflects q_in sampled combinationally in CAPTURE. The bank Q must be a direct register output.

Test Plan:
- Reset 2 cycles, then req_valid=4'b0001, op=10, idx=3: req_ready=4'b0001 at t; jk_j=8'h08, jk_k=0 at t+1; rsp_valid=1, rsp_id=0, rsp_q=1 at t+2; busy high t+1..t+2.
- Toggle idx=3 twice from requester 2 (back-to-back requests): responses rsp_q=0 then rsp_q=1; grants spaced exactly 3 cycles apart.
- All four requesters valid continuously with read ops: grant order 0,1,2,3,0,1; never two ready bits high; rsp_id follows the same order.
- Requesters 1 and 3 both send reset to idx=5 (preset to 1): req 1 granted first, rsp_q=0; req 3 second, rsp_q=0; jk_k=8'h20 in each ISSUE cycle.
- Requester 0 op=11 with idx=9 using WIDTH=10 sized IDX_W=4 but parameter WIDTH=8: jk_j=jk_k=0 in ISSUE; rsp_err=1, rsp_q=0; bank unchanged.
- Reset asserted during ISSUE of a set to idx=1: no rsp_valid; jk_j=0 the next cycle; state IDLE; rr_ptr=3, so requester 0 wins next.
